// File: rtl/vdot_pkg.sv
// -----------------------------------------------------------------------------
// vdot_pkg
// Shared definitions for the dot-product accumulation stage (vdot_acc).
//   DATA_W          : width of partial products and of the result (32)
//   MAX_CHUNKS_DEF  : default chunk limit before a vector is force-completed
//   state_e         : accumulator FSM encoding (IDLE / ACCUM)
// -----------------------------------------------------------------------------
package vdot_pkg;

    localparam int DATA_W         = 32;
    localparam int MAX_CHUNKS_DEF = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage : vdot_pkg

// File: rtl/vdot_acc_if.sv
// -----------------------------------------------------------------------------
// vdot_acc_if
// Input beat stream from the dot-product unit plus the result stream toward
// write-back, bundled as one interface.
//   in_valid/in_data/in_last/in_ready : partial-product stream (upstream side)
//   out_valid/out_data/out_chunks/out_err/out_ready : result stream
// Modports:
//   slave  : view of the accumulator (vdot_acc)
//   master : view of the environment driving beats and draining results
// -----------------------------------------------------------------------------
interface vdot_acc_if #(
    parameter int CNT_W = 5
) ();
    import vdot_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_chunks;
    logic              out_err;
    logic              out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_chunks, out_err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_chunks, out_err
    );

endinterface : vdot_acc_if

// File: rtl/vdot_sat_add.sv
// -----------------------------------------------------------------------------
// vdot_sat_add
// Unsigned 32-bit adder with carry out. When VDOT_ACC_SAT_EN is defined the
// sum is clamped to all-ones on carry; otherwise it wraps modulo 2^32.
//   a_i     : running sum
//   b_i     : incoming partial product
//   sum_o   : wrapped or clamped sum
//   carry_o : carry out of bit 31 (reported in both builds)
// -----------------------------------------------------------------------------
module vdot_sat_add
    import vdot_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o
);

    logic [DATA_W:0] raw;

    assign raw     = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = raw[DATA_W];

`ifdef VDOT_ACC_SAT_EN
    assign sum_o = raw[DATA_W] ? {DATA_W{1'b1}} : raw[DATA_W-1:0];
`else
    assign sum_o = raw[DATA_W-1:0];
`endif

endmodule : vdot_sat_add

// File: rtl/vdot_acc.sv
// -----------------------------------------------------------------------------
// vdot_acc
// Sums 32-bit partial dot products (one per chunk) into one result per
// vector and presents it on a valid/ready output register.
// Optional feature macro: VDOT_ACC_SAT_EN (saturating sum, flagged in out_err).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : vdot_acc_if.slave (input beats in_*, result out_*)
// Parameters:
//   MAX_CHUNKS : chunk limit; reaching it without in_last forces completion
//   CNT_W      : chunk counter width, 2^CNT_W > MAX_CHUNKS
// -----------------------------------------------------------------------------
module vdot_acc
    import vdot_pkg::*;
#(
    parameter int MAX_CHUNKS = MAX_CHUNKS_DEF,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    vdot_acc_if.slave  bus
);

`ifdef VDOT_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Running state: bit DATA_W of acc is a sticky carry for the current vector.
    state_e            state_q, state_d;
    logic [DATA_W:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_chunks_q, out_chunks_d;
    logic              out_err_q, out_err_d;

    logic              in_ready;
    logic              accept;
    logic              complete;
    logic              forced;
    logic [DATA_W:0]   acc_base;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              ovf;

    // A pending result only blocks input if it is not draining this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // In IDLE the accumulator is known empty; use zero explicitly.
    assign acc_base = (state_q == ST_IDLE) ? '0 : acc_q;
    assign cnt_inc  = cnt_q + 1'b1;
    assign forced   = (cnt_inc == CNT_W'(MAX_CHUNKS)) && !bus.in_last;
    assign complete = accept && (bus.in_last || forced);
    assign ovf      = carry || acc_base[DATA_W];

    vdot_sat_add u_add (
        .a_i     (acc_base[DATA_W-1:0]),
        .b_i     (bus.in_data),
        .sum_o   (sum),
        .carry_o (carry)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !complete) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (complete) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: accumulator, counter and result register next values
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chunks_d = out_chunks_q;
        out_err_d    = out_err_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (complete) begin
            acc_d        = '0;
            cnt_d        = '0;
            out_valid_d  = 1'b1;
            out_data_d   = sum;
            out_chunks_d = cnt_inc;
            out_err_d    = forced || (SAT_EN && ovf);
        end else if (accept) begin
            acc_d = {ovf, sum};
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chunks_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chunks_q <= out_chunks_d;
            out_err_q    <= out_err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_chunks = out_chunks_q;
    assign bus.out_err    = out_err_q;

endmodule : vdot_acc

// File: tb/tb_vdot_acc.sv
// -----------------------------------------------------------------------------
// tb_vdot_acc
// Table-driven bench for vdot_acc with a result scoreboard. Expected results
// are queued when the completing beat is accepted and compared when the
// result handshakes out. Expected overflow values follow VDOT_ACC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_vdot_acc;
    import vdot_pkg::*;

    localparam int CNT_W = 5;

    typedef struct {
        logic [31:0] d;
        logic        l;
        bit          has_exp;
        logic [31:0] ed;
        logic [4:0]  ec;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  c;
        logic        e;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t tbl[$];

    vdot_acc_if #(.CNT_W(CNT_W)) bus ();

    vdot_acc #(.MAX_CHUNKS(16), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Result monitor: a handshake will occur at the next rising edge.
    always @(negedge clk) begin
        if (rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", bus.out_data, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data",   bus.out_data,   e.d);
                chk("res_chunks", bus.out_chunks, e.c);
                chk("res_err",    bus.out_err,    e.e);
            end
        end
    end

    // Present one beat; returns 1 ns after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l, input bit has_exp, input exp_t e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (bus.in_ready !== 1'b1) begin
            chk("in_ready_timeout", bus.in_ready, 1);
        end else if (has_exp) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic l, input bit h,
                                input logic [31:0] ed, input logic [4:0] ec, input logic ee);
        vec_t v;
        v.d = d; v.l = l; v.has_exp = h; v.ed = ed; v.ec = ec; v.ee = ee;
        return v;
    endfunction

    function automatic exp_t mke(input logic [31:0] d, input logic [4:0] c, input logic e);
        exp_t x;
        x.d = d; x.c = c; x.e = e;
        return x;
    endfunction

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Vector table
        tbl.push_back(mk(32'h10, 1'b1, 1, 32'h10, 5'd1, 1'b0));
        tbl.push_back(mk(32'd5, 1'b0, 0, 0, 0, 0));
        tbl.push_back(mk(32'd7, 1'b0, 0, 0, 0, 0));
        tbl.push_back(mk(32'd9, 1'b1, 1, 32'd21, 5'd3, 1'b0));
        for (int i = 0; i < 15; i++) tbl.push_back(mk(32'd1, 1'b0, 0, 0, 0, 0));
        tbl.push_back(mk(32'd1, 1'b0, 1, 32'd16, 5'd16, 1'b1));
        tbl.push_back(mk(32'd3, 1'b1, 1, 32'd3, 5'd1, 1'b0));
        tbl.push_back(mk(32'hFFFF_FFF0, 1'b0, 0, 0, 0, 0));
`ifdef VDOT_ACC_SAT_EN
        tbl.push_back(mk(32'h20, 1'b1, 1, 32'hFFFF_FFFF, 5'd2, 1'b1));
`else
        tbl.push_back(mk(32'h20, 1'b1, 1, 32'h10, 5'd2, 1'b0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid",  bus.out_valid,  0);
        chk("rst_out_data",   bus.out_data,   0);
        chk("rst_out_chunks", bus.out_chunks, 0);
        chk("rst_out_err",    bus.out_err,    0);
        chk("rst_in_ready",   bus.in_ready,   1);
        rst = 1'b1;

        // Ignored beats when in_valid is low
        @(posedge clk); #1;
        bus.in_data = 32'h55; bus.in_last = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_valid", bus.out_valid, 0);

        // Table run, back to back
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            send(tbl[i].d, tbl[i].l, tbl[i].has_exp, mke(tbl[i].ed, tbl[i].ec, tbl[i].ee));
            if (tbl[i].has_exp) chk("latency_valid", bus.out_valid, 1);
        end
        repeat (2) @(negedge clk);
        chk("drained", bus.out_valid, 0);

        // Backpressure: pending result blocks input and stays stable
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'h30, 1'b1, 1, mke(32'h30, 5'd1, 1'b0));
        bus.in_valid = 1'b1; bus.in_data = 32'h44; bus.in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready,   0);
            chk("bp_valid",    bus.out_valid,  1);
            chk("bp_data",     bus.out_data,   32'h30);
            chk("bp_chunks",   bus.out_chunks, 1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(32'h44, 1'b1, 1, mke(32'h44, 5'd1, 1'b0));
        chk("bp_nobubble_valid", bus.out_valid, 1);
        chk("bp_nobubble_data",  bus.out_data,  32'h44);
        repeat (2) @(negedge clk);

        // Reset mid-vector discards the partial sum
        @(posedge clk); #1;
        send(32'd1, 1'b0, 0, e);
        send(32'd2, 1'b0, 0, e);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid",  bus.out_valid, 0);
        chk("midrst_data",   bus.out_data,  0);
        chk("midrst_ready",  bus.in_ready,  1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        send(32'd3, 1'b1, 1, mke(32'd3, 5'd1, 1'b0));
        repeat (2) @(negedge clk);

        // Reset with a pending, unaccepted result
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'd9, 1'b1, 1, mke(32'd9, 5'd1, 1'b0));
        @(negedge clk);
        chk("pend_data", bus.out_data, 32'd9);
        rst = 1'b0;
        #1;
        chk("pendrst_valid",  bus.out_valid,  0);
        chk("pendrst_data",   bus.out_data,   0);
        chk("pendrst_chunks", bus.out_chunks, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        send(32'd3, 1'b1, 1, mke(32'd3, 5'd1, 1'b0));
        repeat (3) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vdot_acc

// File: doc/vdot_acc.md
# vdot_acc

Accumulation stage directly downstream of the vector dot-product unit. It consumes the 32-bit partial dot products that unit produces, one per vector chunk, and sums them into one result per full-length vector. It presents that result on a valid/ready output toward the write-back or activation stage. The result is optionally saturating, and the block also flags vectors that overrun a configured chunk limit.

## Interface
- `MAX_CHUNKS`, default 16: maximum chunks per vector before forced completion.
- `CNT_W`, default 5: chunk-counter width; must satisfy 2^CNT_W > MAX_CHUNKS.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` holds a valid partial product.
- `in_data` input 32: unsigned partial dot product from the dot-product unit.
- `in_last` input 1: marks the final chunk of the current vector; sampled with `in_valid`.
- `in_ready` output 1: block can accept a beat this cycle.
- `out_valid` output 1: `out_data` holds a completed vector result.
- `out_data` output 32: accumulated result.
- `out_chunks` output CNT_W: number of chunks summed into `out_data`.
- `out_err` output 1: result was force-completed at MAX_CHUNKS, or saturated (SAT build).
- `out_ready` input 1: downstream accepts the result.

## Operation
- Beat accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`, so a new vector can complete in the same cycle the old result drains.
- FSM states:
  - IDLE: accumulator = 0, count = 0.
  - ACCUM: at least one chunk summed, no `in_last` seen yet.
- Transitions:
  - IDLE→ACCUM on an accepted beat with `in_last=0`.
  - ACCUM→IDLE on an accepted beat with `in_last=1`, or when count reaches MAX_CHUNKS.
  - IDLE→IDLE on an accepted beat with `in_last=1`; this is a single-chunk vector.
- On completion, the final sum (acc + in_data) loads the output register:
  - `out_valid` set.
  - `out_chunks` = count+1.
  - Accumulator and count cleared in the same edge.
- Forced completion: an accepted beat that makes count+1 == MAX_CHUNKS with `in_last=0` completes with `out_err=1`. Subsequent beats start a new vector.
- Arithmetic: accumulator is 33 bits internally; bit 32 records the carry. Output behaviour on carry depends on configuration.
- `out_valid` is cleared on `out_valid && out_ready`, unless a completion loads the register in the same cycle, in which case it stays 1 with the new data.
- Output register contents are held stable while `out_valid && !out_ready`.

## Timing
- Result latency: `out_valid` rises one cycle after the accepting edge of the `in_last` beat.
- Throughput: one beat per cycle when unstalled.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_chunks`=0, `out_err`=0.
  - Accumulator=0, state IDLE.
  - `in_ready` evaluates to 1.
- Reset asserted mid-vector discards the partial sum and any pending unaccepted result.
- `in_data` and `in_last` are ignored when `in_valid=0`.

## Configuration
- `VDOT_ACC_SAT_EN` defined: any carry out of bit 31 clamps the running sum to 32'hFFFF_FFFF. The clamp persists for the rest of the vector, and `out_err`=1 on that result.
- `VDOT_ACC_SAT_EN` undefined: sum wraps modulo 2^32 and saturation does not affect `out_err`; `out_err` reflects forced completion only.

## Structure
- Shared package `vdot_pkg` holds:
  - data width constant (32);
  - FSM state encoding (IDLE, ACCUM);
  - default MAX_CHUNKS.
- One sub-module, `vdot_sat_add`: 32-bit add with carry out and an optional clamp, selected by the macro.

## Test plan
- Single-chunk vector: in_data=0x10, in_last=1 → next cycle `out_valid`=1, `out_data`=0x10, `out_chunks`=1, `out_err`=0.
- Three chunks 5, 7, 9, back-to-back, last on the third → `out_data`=21, `out_chunks`=3, one cycle after the third beat.
- Backpressure: hold `out_ready`=0 with a result pending, then present a beat → `in_ready`=0 and output stable. Raise `out_ready` while the next `in_last` beat arrives → new result loads with no bubble.
- 16 beats of value 1 with `in_last`=0 → forced completion: `out_data`=16, `out_chunks`=16, `out_err`=1. The 17th beat starts a fresh vector.
- Overflow with chunks 0xFFFF_FFF0 then 0x20 (last):
  - SAT build → `out_data`=0xFFFF_FFFF, `out_err`=1.
  - Non-SAT build → `out_data`=0x10, `out_err`=0.
- Assert `rst` low after two chunks → outputs 0 immediately. Post-reset vector 3 (last) → `out_data`=3.
